// File: rtl/status_updater_pkg.sv
// Shared sizing defaults and FSM encoding for the icache status-array write controller.
package status_updater_pkg;

   localparam int unsigned DEF_ADDR_WIDTH    = 4;
   localparam int unsigned DEF_NUM_BLOCKS    = 8;
   localparam int unsigned DEF_ROW_WIDTH     = DEF_NUM_BLOCKS;
   localparam int unsigned DEF_BLK_IDX_WIDTH = $clog2(DEF_NUM_BLOCKS);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Binary index to one-hot vector; builds the per-block write mask.
module onehot_decoder #(
   parameter int unsigned IDX_WIDTH = 3,
   parameter int unsigned OUT_WIDTH = 8
) (
   input  logic [IDX_WIDTH-1:0] idx,
   output logic [OUT_WIDTH-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         if (idx == i[IDX_WIDTH-1:0]) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/status_updater.sv
// Write-side controller for the icache valid-bit array: zero sweeps on reset/flush,
// single-cycle masked writes for fill-complete and invalidate requests.
module status_updater
   import status_updater_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_BLOCKS    = DEF_NUM_BLOCKS,
   parameter int unsigned ROW_WIDTH     = DEF_ROW_WIDTH,
   parameter int unsigned BLK_IDX_WIDTH = DEF_BLK_IDX_WIDTH
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     i_halt,
   input  logic [ADDR_WIDTH-1:0]    i_req_addr,
   input  logic [BLK_IDX_WIDTH-1:0] i_req_block,
   input  logic                     i_req_op,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic                     i_flush,
   output logic [ADDR_WIDTH-1:0]    o_w_addr,
   output logic [ROW_WIDTH-1:0]     o_w_data,
   output logic [NUM_BLOCKS-1:0]    o_w_wmask,
   output logic                     o_w_valid,
   output logic                     o_init_done,
   output logic                     o_busy
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   row_q, row_d;
   logic                    flush_pend_q, flush_pend_d;
   logic                    init_done_q, init_done_d;
   logic                    w_valid_q, w_valid_d;
   logic [ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
   logic [ROW_WIDTH-1:0]    w_data_q, w_data_d;
   logic [NUM_BLOCKS-1:0]   w_wmask_q, w_wmask_d;

   logic [NUM_BLOCKS-1:0]   req_mask;
   logic                    req_accept;
   logic                    last_row;

   onehot_decoder #(
      .IDX_WIDTH (BLK_IDX_WIDTH),
      .OUT_WIDTH (NUM_BLOCKS)
   ) u_mask_dec (
      .idx    (i_req_block),
      .onehot (req_mask)
   );

   // A flush pulse in the same cycle blocks acceptance so it can never be overtaken.
   assign o_req_ready = (state_q == ST_IDLE) & ~flush_pend_q & ~i_halt & ~i_flush;
   assign req_accept  = i_req_valid & o_req_ready;
   assign last_row    = (row_q == {ADDR_WIDTH{1'b1}});

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      flush_pend_d = flush_pend_q | i_flush;
      init_done_d  = init_done_q;
      w_valid_d    = w_valid_q;
      w_addr_d     = w_addr_q;
      w_data_d     = w_data_q;
      w_wmask_d    = w_wmask_q;

      if (!i_halt) begin
         unique case (state_q)
            ST_INIT, ST_FLUSH: begin
               w_valid_d = 1'b1;
               w_addr_d  = row_q;
               w_data_d  = '0;
               w_wmask_d = '1;
               row_d     = row_q + 1'b1;
               if (last_row) begin
                  state_d = ST_IDLE;
                  if (state_q == ST_INIT) begin
                     init_done_d = 1'b1;
                  end
               end
            end
            ST_IDLE: begin
               w_valid_d = 1'b0;
               w_addr_d  = '0;
               w_data_d  = '0;
               w_wmask_d = '0;
               if (flush_pend_q) begin
                  state_d      = ST_FLUSH;
                  flush_pend_d = i_flush;
               end else if (req_accept) begin
                  w_valid_d = 1'b1;
                  w_addr_d  = i_req_addr;
                  w_data_d  = {ROW_WIDTH{i_req_op}};
                  w_wmask_d = req_mask;
               end
            end
            default: begin
               state_d = ST_INIT;
               row_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q      <= ST_INIT;
         row_q        <= '0;
         flush_pend_q <= 1'b0;
         init_done_q  <= 1'b0;
         w_valid_q    <= 1'b0;
         w_addr_q     <= '0;
         w_data_q     <= '0;
         w_wmask_q    <= '0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         flush_pend_q <= flush_pend_d;
         init_done_q  <= init_done_d;
         w_valid_q    <= w_valid_d;
         w_addr_q     <= w_addr_d;
         w_data_q     <= w_data_d;
         w_wmask_q    <= w_wmask_d;
      end
   end

   assign o_w_valid   = w_valid_q;
   assign o_w_addr    = w_addr_q;
   assign o_w_data    = w_data_q;
   assign o_w_wmask   = w_wmask_q;
   assign o_init_done = init_done_q;
   assign o_busy      = (state_q == ST_INIT) | (state_q == ST_FLUSH);

endmodule

// File: tb/tb_status_updater.sv
// Bench for status_updater: directed vector table, corner-case sequences and random traffic
// checked against a sweep/request level reference model.
module tb_status_updater;

   logic       clk = 1'b0;
   logic       srst, i_halt, i_req_op, i_req_valid, i_flush;
   logic [3:0] i_req_addr;
   logic [2:0] i_req_block;
   logic       o_req_ready, o_w_valid, o_init_done, o_busy;
   logic [3:0] o_w_addr;
   logic [7:0] o_w_data, o_w_wmask;

   int n_cmp = 0;
   int n_bad = 0;

   status_updater dut (
      .clk         (clk),
      .srst        (srst),
      .i_halt      (i_halt),
      .i_req_addr  (i_req_addr),
      .i_req_block (i_req_block),
      .i_req_op    (i_req_op),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_flush     (i_flush),
      .o_w_addr    (o_w_addr),
      .o_w_data    (o_w_data),
      .o_w_wmask   (o_w_wmask),
      .o_w_valid   (o_w_valid),
      .o_init_done (o_init_done),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // Reference model: is a sweep running, which row comes next, and was it the power-on one.
   bit         m_sweeping = 1'b1;
   bit         m_first    = 1'b1;
   int         m_row      = 0;
   bit         m_pend     = 1'b0;
   bit         m_done     = 1'b0;
   logic       e_v        = 1'b0;
   logic [3:0] e_a        = '0;
   logic [7:0] e_d        = '0;
   logic [7:0] e_m        = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return !m_sweeping && !m_pend && !i_halt && !i_flush;
   endfunction

   task automatic model_step();
      bit acc;
      acc = i_req_valid && m_ready();
      if (srst) begin
         m_sweeping = 1'b1; m_first = 1'b1; m_row = 0; m_pend = 1'b0; m_done = 1'b0;
         e_v = 1'b0; e_a = '0; e_d = '0; e_m = '0;
         return;
      end
      if (!i_halt) begin
         if (m_sweeping) begin
            e_v = 1'b1; e_a = m_row[3:0]; e_d = 8'h00; e_m = 8'hFF;
            m_row++;
            if (m_row == 16) begin
               m_row = 0;
               m_sweeping = 1'b0;
               if (m_first) m_done = 1'b1;
               m_first = 1'b0;
            end
         end else begin
            e_v = 1'b0; e_a = '0; e_d = '0; e_m = '0;
            if (m_pend) begin
               m_sweeping = 1'b1;
               m_first = 1'b0;
               m_pend = 1'b0;
            end else if (acc) begin
               e_v = 1'b1;
               e_a = i_req_addr;
               e_d = i_req_op ? 8'hFF : 8'h00;
               e_m = 8'(1 << i_req_block);
            end
         end
      end
      if (i_flush) m_pend = 1'b1;
   endtask

   task automatic tick();
      #1;
      check("req_ready", 32'(o_req_ready), 32'(m_ready()));
      model_step();
      @(posedge clk);
      #1;
      check("w_valid", 32'(o_w_valid), 32'(e_v));
      check("w_addr", 32'(o_w_addr), 32'(e_a));
      check("w_data", 32'(o_w_data), 32'(e_d));
      check("w_wmask", 32'(o_w_wmask), 32'(e_m));
      check("init_done", 32'(o_init_done), 32'(m_done));
      check("busy", 32'(o_busy), 32'(m_sweeping));
   endtask

   task automatic idle_inputs();
      srst = 1'b0; i_halt = 1'b0; i_flush = 1'b0; i_req_valid = 1'b0;
      i_req_addr = '0; i_req_block = '0; i_req_op = 1'b0;
   endtask

   typedef struct {
      logic       valid;
      logic [3:0] addr;
      logic [2:0] blk;
      logic       op;
      logic       ev;
      logic [3:0] ea;
      logic [7:0] ed;
      logic [7:0] em;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b1, 4'd5,  3'd3, 1'b1, 1'b1, 4'd5,  8'hFF, 8'h08};
      tbl[1] = '{1'b1, 4'd5,  3'd7, 1'b0, 1'b1, 4'd5,  8'h00, 8'h80};
      tbl[2] = '{1'b1, 4'd1,  3'd0, 1'b1, 1'b1, 4'd1,  8'hFF, 8'h01};
      tbl[3] = '{1'b1, 4'd2,  3'd1, 1'b1, 1'b1, 4'd2,  8'hFF, 8'h02};
      tbl[4] = '{1'b1, 4'd3,  3'd2, 1'b0, 1'b1, 4'd3,  8'h00, 8'h04};
      tbl[5] = '{1'b1, 4'd4,  3'd6, 1'b1, 1'b1, 4'd4,  8'hFF, 8'h40};
      tbl[6] = '{1'b0, 4'd9,  3'd4, 1'b1, 1'b0, 4'd0,  8'h00, 8'h00};
      tbl[7] = '{1'b1, 4'd15, 3'd5, 1'b0, 1'b1, 4'd15, 8'h00, 8'h20};

      // Reset: first edge without a ready check since DUT state is still unknown.
      idle_inputs();
      srst = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      tick();
      check("rst_busy", 32'(o_busy), 32'd1);
      check("rst_init_done", 32'(o_init_done), 32'd0);
      check("rst_w_valid", 32'(o_w_valid), 32'd0);

      // Power-on sweep: edge k writes row k-1.
      srst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("init_row", 32'(o_w_addr), 32'(k - 1));
         check("init_mask", 32'(o_w_wmask), 32'hFF);
      end
      tick();
      check("init_done_e17", 32'(o_init_done), 32'd1);
      check("init_idle_e17", 32'(o_busy), 32'd0);
      check("init_valid_e17", 32'(o_w_valid), 32'd0);
      tick();
      tick();

      // Directed request vectors, one per cycle (back-to-back where valid).
      for (int i = 0; i < 8; i++) begin
         i_req_valid = tbl[i].valid;
         i_req_addr  = tbl[i].addr;
         i_req_block = tbl[i].blk;
         i_req_op    = tbl[i].op;
         tick();
         check("vec_valid", 32'(o_w_valid), 32'(tbl[i].ev));
         check("vec_addr", 32'(o_w_addr), 32'(tbl[i].ea));
         check("vec_data", 32'(o_w_data), 32'(tbl[i].ed));
         check("vec_mask", 32'(o_w_wmask), 32'(tbl[i].em));
      end
      idle_inputs();
      tick();

      // Flush with a simultaneous request to row 9, then a second flush mid-sweep.
      i_flush = 1'b1; i_req_valid = 1'b1; i_req_addr = 4'd9; i_req_block = 3'd1; i_req_op = 1'b1;
      #1;
      check("flush_blocks_req", 32'(o_req_ready), 32'd0);
      tick();
      idle_inputs();
      tick();
      check("flush_f1_valid", 32'(o_w_valid), 32'd0);
      check("flush_f1_busy", 32'(o_busy), 32'd1);
      for (int k = 0; k < 16; k++) begin
         if (k == 8) i_flush = 1'b1;
         tick();
         i_flush = 1'b0;
         check("flush1_row", 32'(o_w_addr), 32'(k));
         check("flush1_valid", 32'(o_w_valid), 32'd1);
      end
      tick();
      check("gap_valid", 32'(o_w_valid), 32'd0);
      for (int k = 0; k < 16; k++) begin
         tick();
         check("flush2_row", 32'(o_w_addr), 32'(k));
      end
      tick();
      check("after_flush2_busy", 32'(o_busy), 32'd0);
      #1;
      check("after_flush2_ready", 32'(o_req_ready), 32'd1);
      tick();

      // Halt for three cycles while row 6 is on the write port.
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      for (int n = 0; n < 40 && !(o_w_valid && o_w_addr == 4'd6); n++) tick();
      check("reach_row6", 32'(o_w_addr), 32'd6);
      i_halt = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         check("halt_addr", 32'(o_w_addr), 32'd6);
         check("halt_valid", 32'(o_w_valid), 32'd1);
      end
      #1;
      check("halt_ready", 32'(o_req_ready), 32'd0);
      i_halt = 1'b0;
      for (int k = 7; k < 16; k++) begin
         tick();
         check("post_halt_row", 32'(o_w_addr), 32'(k));
      end
      tick();
      tick();

      // Reset during a flush at row 10 with another flush pending.
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      for (int n = 0; n < 40 && !(o_w_valid && o_w_addr == 4'd10); n++) tick();
      check("reach_row10", 32'(o_w_addr), 32'd10);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      srst = 1'b1;
      tick();
      check("mid_rst_done", 32'(o_init_done), 32'd0);
      check("mid_rst_busy", 32'(o_busy), 32'd1);
      check("mid_rst_valid", 32'(o_w_valid), 32'd0);
      srst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         check("reinit_row", 32'(o_w_addr), 32'(k));
      end
      for (int n = 0; n < 4; n++) begin
         tick();
         check("no_extra_flush", 32'(o_busy), 32'd0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         srst        = ($urandom % 300) == 0;
         i_halt      = ($urandom % 8) == 0;
         i_flush     = ($urandom % 50) == 0;
         i_req_valid = 1'($urandom % 2);
         i_req_addr  = 4'($urandom);
         i_req_block = 3'($urandom);
         i_req_op    = 1'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/status_updater.md
# status_updater

Write-side controller for the instruction cache status array's write port. It drives the per-block valid bits in that array. Out of reset, and on every flush, it sweeps all rows to zero. In idle it turns fill-complete and invalidate requests into single-cycle masked writes, so no read-modify-write is ever needed. It sits between the miss/fill logic and the status array's write port, and honours the same `i_halt` stall as the array.

## Interface
Parameters (defaults come from `shared_params.vh`):
- `ADDR_WIDTH`, 4: row address width; the array has 2^ADDR_WIDTH = 16 rows.
- `NUM_BLOCKS`, 8: number of blocks (valid bits) per row.
- `ROW_WIDTH`, 8: row data width; equals `NUM_BLOCKS`, one status bit per block.
- `BLK_IDX_WIDTH`, 3: equals `$clog2(NUM_BLOCKS)`.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `srst`, input, 1: reset, synchronous and active-high.
- `i_halt`, input, 1: stall; freezes all state and all outputs.
- `i_req_addr`, input, ADDR_WIDTH: row of the request.
- `i_req_block`, input, BLK_IDX_WIDTH: block index within the row.
- `i_req_op`, input, 1: 1 = set valid (fill done), 0 = invalidate block.
- `i_req_valid`, input, 1: request present.
- `o_req_ready`, output, 1: request accepted when `i_req_valid & o_req_ready`; combinational.
- `i_flush`, input, 1: single-cycle pulse requesting invalidation of the whole array.
- `o_w_addr`, output, ADDR_WIDTH: to the status array write address.
- `o_w_data`, output, ROW_WIDTH: to the status array write data.
- `o_w_wmask`, output, NUM_BLOCKS: to the status array write mask; bit set = block written.
- `o_w_valid`, output, 1: to the status array write valid.
- `o_init_done`, output, 1: high once the first sweep completes; cleared only by `srst`.
- `o_busy`, output, 1: high when state is INIT or FLUSH.

## Operation
- **States:** INIT, IDLE, FLUSH. `srst` forces INIT.
- **Reset values:**
  - row counter = 0, `flush_pend` = 0, `o_init_done` = 0.
  - `o_w_valid` = 0, `o_w_addr` = 0, `o_w_data` = 0, `o_w_wmask` = 0.
  - `o_busy` = 1.
- **INIT and FLUSH (sweep):** each un-halted cycle writes row = counter with data 0 and mask all-ones, then increments the counter.
  - After the write to row 2^ADDR_WIDTH−1, the counter wraps to 0 and the state goes to IDLE.
  - Leaving INIT sets `o_init_done`.
- **IDLE with an accepted request:** the next cycle writes `o_w_addr` = `i_req_addr`, `o_w_wmask` = one-hot(`i_req_block`), `o_w_data` = {NUM_BLOCKS{`i_req_op`}}.
- **IDLE with no accepted request:** `o_w_valid` = 0 and `o_w_addr`/`o_w_data`/`o_w_wmask` = 0.
- **Flush capture:** `i_flush` high sets the sticky `flush_pend` in any state, including while halted.
- **IDLE with `flush_pend` set:** the state goes to FLUSH and `flush_pend` is cleared, with priority over requests.
- **`o_req_ready`** = (state == IDLE) & ~`flush_pend` & ~`i_halt` & ~`i_flush`.
  - Consequence: a flush pulse and a request in the same cycle means the request is not accepted.
- **Flush during FLUSH:** the current sweep completes, then a second sweep runs, because `flush_pend` was set again.
- **Flush during INIT:** serviced immediately after INIT completes.
- **Halt:** state, counter and all outputs hold their values; `o_w_valid` holds, and the array's gated clock makes the held write a no-op until release. After release the sweep continues from the held row, so no row is skipped or repeated.
- **`srst` mid-sweep or mid-request:** returns to INIT at counter 0; `flush_pend` is cleared.

## Timing
- **Outputs:** all write-port outputs are registered.
- **Request latency:** a request accepted at edge N produces `o_w_valid` = 1 in the cycle after edge N. Throughput is one request per cycle.
- **INIT sweep:** on the k-th un-halted rising edge with `srst` low (k = 1..16), `o_w_addr` = k−1 and `o_w_valid` = 1. After edge 17: `o_w_valid` = 0, `o_init_done` = 1, `o_busy` = 0, state IDLE.
- **Flush latency:** a flush pulse at edge F, in IDLE with no halt, enters FLUSH at F+1. Rows 0..15 are written after edges F+2..F+17; IDLE resumes, and `o_req_ready` can be high, after F+18.
- **Sweep length:** 16 write cycles, with no gaps unless halted.

## Structure
- `shared_params.vh`: add `BLK_IDX_WIDTH` and localparams `ST_INIT`/`ST_IDLE`/`ST_FLUSH` (2-bit state encoding).
- One sub-module, `onehot_decoder` (BLK_IDX_WIDTH → NUM_BLOCKS), for the write mask.
- The FSM, row counter and output registers stay in `status_updater`.

## Test plan
- **Reset release:** release `srst` and run 20 cycles. Expect 16 writes to addresses 0..15 with data 0x00 and mask 0xFF, then `o_init_done` = 1 after edge 17.
- **Single request:** in IDLE, request addr 5, block 3, op 1. The next cycle shows addr 5, mask 0x08, data 0xFF, `o_w_valid` = 1. Then op 0 on block 7 of addr 5 gives mask 0x80, data 0x00.
- **Back-to-back requests:** hold `i_req_valid` for 4 cycles with addrs 1, 2, 3, 4. Expect 4 consecutive writes with no bubbles, each one cycle after acceptance.
- **Flush:**
  - Pulse `i_flush` in IDLE at the same cycle as a request to addr 9. The request is not accepted; `o_req_ready` stays low, and the 16-row zero sweep occurs with the first write after F+2.
  - Pulse `i_flush` again mid-sweep. Expect a second full sweep.
- **Halt mid-sweep:** assert `i_halt` for 3 cycles while `o_w_addr` = 6. Outputs hold addr 6 and `o_req_ready` = 0. After release, writes continue with 7..15 and no duplicates beyond the held cycles.
- **Reset mid-operation:** assert `srst` during a FLUSH at row 10 with `flush_pend` set. Expect INIT restarting at row 0, `o_init_done` = 0, and no extra flush afterward.
